// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one data-memory requester.
// The requester holds valid/we/addr/wdata stable until ready.
interface dmem_arbiter_if;
  logic        valid;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output valid, we, addr, wdata,
    input  ready, resp_valid, rdata, err
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, resp_valid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port read-first data RAM.
// Port a is the load/store unit, port b the UART loader.
module dmem_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'd400000,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  dmem_arbiter_if.slave a,
  dmem_arbiter_if.slave b,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_di,
  input  logic [31:0] ram_dout
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  port_e       last_grant;
  port_e       resp_sel;
  logic        resp_pend;
  logic        resp_err;

  logic        gnt_a;
  logic        gnt_b;
  logic        fire;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        in_range;

  // Grants are masked in reset so ready and the RAM stay quiet.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rstn) begin
      if (a.valid && b.valid) begin
        if (FIXED_PRIO || last_grant == PORT_B)
          gnt_a = 1'b1;
        else
          gnt_b = 1'b1;
      end else begin
        gnt_a = a.valid;
        gnt_b = b.valid;
      end
    end
  end

  assign fire      = gnt_a | gnt_b;
  assign sel_we    = gnt_b ? b.we    : a.we;
  assign sel_addr  = gnt_b ? b.addr  : a.addr;
  assign sel_wdata = gnt_b ? b.wdata : a.wdata;
  assign in_range  = sel_addr <= ADDR_LIMIT;

  assign a.ready = gnt_a;
  assign b.ready = gnt_b;

  assign ram_en   = fire & in_range;
  assign ram_we   = ram_en & sel_we;
  assign ram_addr = ram_en ? sel_addr  : 32'h0;
  assign ram_di   = ram_en ? sel_wdata : 32'h0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= PORT_B;
      resp_sel   <= PORT_A;
      resp_pend  <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      resp_pend <= fire;
      resp_sel  <= gnt_b ? PORT_B : PORT_A;
      resp_err  <= fire & ~in_range;
      if (fire)
        last_grant <= gnt_b ? PORT_B : PORT_A;
    end
  end

  // Out-of-range responses carry zero data, never stale RAM output.
  assign a.resp_valid = resp_pend && resp_sel == PORT_A;
  assign b.resp_valid = resp_pend && resp_sel == PORT_B;
  assign a.err        = a.resp_valid & resp_err;
  assign b.err        = b.resp_valid & resp_err;
  assign a.rdata      = (a.resp_valid && !resp_err) ? ram_dout : 32'h0;
  assign b.rdata      = (b.resp_valid && !resp_err) ? ram_dout : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: random and directed traffic on
// a round-robin instance plus a short fixed-priority check.
module tb_dmem_arbiter;
  localparam logic [31:0] LIMIT = 32'd400000;
  localparam logic [31:0] K1    = 32'h5A5A0000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if a_if ();
  dmem_arbiter_if b_if ();
  dmem_arbiter_if p_a ();
  dmem_arbiter_if p_b ();

  logic        ram_en, ram_we;
  logic [31:0] ram_addr, ram_di;
  logic [31:0] ram_dout = 32'h0;
  logic        r1_en, r1_we;
  logic [31:0] r1_addr, r1_di;
  logic [31:0] r1_dout = 32'h0;

  dmem_arbiter #(.ADDR_LIMIT(LIMIT), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rstn(rstn), .a(a_if), .b(b_if),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_di(ram_di), .ram_dout(ram_dout)
  );

  dmem_arbiter #(.ADDR_LIMIT(LIMIT), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rstn(rstn), .a(p_a), .b(p_b),
    .ram_en(r1_en), .ram_we(r1_we), .ram_addr(r1_addr),
    .ram_di(r1_di), .ram_dout(r1_dout)
  );

  int nchk  = 0;
  int nfail = 0;
  int cyc   = 0;

  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Sparse address map: small addresses and the top of the range.
  function automatic int ridx(logic [31:0] ad);
    if (ad < 32) return int'(ad);
    if (ad >= 32'd399990 && ad <= 32'd400001)
      return int'(ad - 32'd399990) + 32;
    return -1;
  endfunction

  // Read-first, 1-cycle RAM attached to the round-robin instance.
  logic [31:0] mem [0:63] = '{default: 32'h0};
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= (ridx(ram_addr) >= 0) ? mem[ridx(ram_addr)] : 32'h0;
      if (ram_we && ridx(ram_addr) >= 0)
        mem[ridx(ram_addr)] <= ram_di;
    end
  end

  // Fixed-priority instance sees a ROM of addr ^ K1.
  always @(posedge clk) begin
    if (r1_en && !r1_we)
      r1_dout <= r1_addr ^ K1 ^ r1_di;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_mem [0:63] = '{default: 32'h0};
  bit          last_b = 1'b1;

  // Reference model: who should win, what the RAM should see, and
  // what the response will carry.
  always @(negedge clk) begin : model
    bit          ga, gb, we, inr;
    logic [31:0] ad, wd;
    exp_t        e;
    if (!rstn) begin
      exp_q.delete();
      last_b <= 1'b1;
      chk("reset_drive",
          {a_if.ready, b_if.ready, ram_en, ram_we, ram_addr, ram_di}, '0);
    end else begin
      ga  = a_if.valid && (!b_if.valid || last_b);
      gb  = b_if.valid && !ga;
      we  = ga ? a_if.we    : b_if.we;
      ad  = ga ? a_if.addr  : b_if.addr;
      wd  = ga ? a_if.wdata : b_if.wdata;
      inr = ad <= LIMIT;
      chk("grant", {a_if.ready, b_if.ready}, {ga, gb});
      chk("ram_drive", {ram_en, ram_we, ram_addr, ram_di},
          ((ga || gb) && inr) ? {1'b1, we, ad, wd} : 66'h0);
      if (ga || gb) begin
        e.port  = gb;
        e.err   = !inr;
        e.rdata = inr ? exp_mem[ridx(ad)] : 32'h0;
        e.due   = cyc + 1;
        exp_q.push_back(e);
        if (inr && we) exp_mem[ridx(ad)] <= wd;
        last_b <= gb;
      end
    end
  end

  // Monitor: pops an expectation whenever a response appears.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [33:0] ea, eb;
    if (!rstn) begin
      chk("reset_resp", {a_if.resp_valid, a_if.err, a_if.rdata,
                         b_if.resp_valid, b_if.err, b_if.rdata}, '0);
    end else if (a_if.resp_valid || b_if.resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_resp", {a_if.resp_valid, b_if.resp_valid}, 2'b00);
      end else begin
        e  = exp_q.pop_front();
        ea = e.port ? 34'h0 : {1'b1, e.err, e.rdata};
        eb = e.port ? {1'b1, e.err, e.rdata} : 34'h0;
        chk("resp_cycle", cyc, e.due);
        chk("resp_a", {a_if.resp_valid, a_if.err, a_if.rdata}, ea);
        chk("resp_b", {b_if.resp_valid, b_if.err, b_if.rdata}, eb);
      end
    end else begin
      chk("idle_resp", {a_if.err, a_if.rdata, b_if.err, b_if.rdata}, '0);
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk("resp_missing", {a_if.resp_valid, b_if.resp_valid},
            {!e.port, e.port});
      end
    end
  end

  bit          af, bf, par, pbr, parv;
  logic [31:0] pard;

  task automatic step();
    @(negedge clk);
    af   = a_if.valid && a_if.ready;
    bf   = b_if.valid && b_if.ready;
    par  = p_a.ready;
    pbr  = p_b.ready;
    parv = p_a.resp_valid;
    pard = p_a.rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic req(bit p, bit we, logic [31:0] ad, logic [31:0] wd);
    bit fired = 1'b0;
    if (p) begin
      b_if.valid = 1'b1; b_if.we = we; b_if.addr = ad; b_if.wdata = wd;
    end else begin
      a_if.valid = 1'b1; a_if.we = we; a_if.addr = ad; a_if.wdata = wd;
    end
    for (int i = 0; i < 20 && !fired; i++) begin
      step();
      fired = p ? bf : af;
    end
    chk("req_fired", fired, 1'b1);
    a_if.valid = 1'b0;
    b_if.valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1, 2, 3: return 32'($urandom_range(0, 15));
      4:          return 32'd399998 + 32'($urandom_range(0, 2));
      5:          return LIMIT;
      6:          return LIMIT + 32'd1 + 32'($urandom_range(0, 3));
      default:    return 32'hFFFF_FFFF;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int na, nb;

  initial begin
    a_if.valid = 0; a_if.we = 0; a_if.addr = 0; a_if.wdata = 0;
    b_if.valid = 0; b_if.we = 0; b_if.addr = 0; b_if.wdata = 0;
    p_a.valid = 0; p_a.we = 0; p_a.addr = 0; p_a.wdata = 0;
    p_b.valid = 0; p_b.we = 0; p_b.addr = 0; p_b.wdata = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    step();

    req(1'b1, 1'b1, 32'd10, 32'hA0A0_0010);
    req(1'b1, 1'b1, 32'd20, 32'hB0B0_0020);
    step();

    // Continuous contention: A first (last grant is B), then alternate.
    a_if.valid = 1; a_if.we = 0; a_if.addr = 32'd10;
    b_if.valid = 1; b_if.we = 0; b_if.addr = 32'd20;
    p_a.valid = 1; p_a.we = 0; p_a.addr = 32'd10;
    p_b.valid = 1; p_b.we = 0; p_b.addr = 32'd20;
    na = 0;
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      na += int'(af);
      nb += int'(bf);
      chk("fp_grant", {par, pbr}, 2'b10);
      if (i > 0) chk("fp_resp", {parv, pard}, {1'b1, 32'd10 ^ K1});
    end
    chk("rr_count_a", na, 3);
    chk("rr_count_b", nb, 3);
    a_if.valid = 0;
    b_if.valid = 0;
    p_a.valid  = 0;
    step();
    chk("fp_b_after_a_drops", pbr, 1'b1);
    p_b.valid = 0;
    step();

    req(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
    req(1'b0, 1'b0, 32'd5, 32'h0);
    step();

    req(1'b1, 1'b1, 32'd7, 32'h11);
    req(1'b0, 1'b1, 32'd7, 32'h22);
    req(1'b0, 1'b0, 32'd7, 32'h0);

    req(1'b1, 1'b1, LIMIT + 32'd1, 32'h1234_5678);
    req(1'b1, 1'b0, LIMIT + 32'd1, 32'h0);
    req(1'b1, 1'b1, LIMIT, 32'hCAFE_F00D);
    req(1'b1, 1'b0, LIMIT, 32'h0);
    step();

    for (int i = 0; i < 3000; i++) begin
      step();
      if (!a_if.valid || af) begin
        a_if.valid = ($urandom_range(0, 3) != 0);
        a_if.we    = 1'($urandom_range(0, 1));
        a_if.addr  = rand_addr();
        a_if.wdata = $urandom;
      end
      if (!b_if.valid || bf) begin
        b_if.valid = ($urandom_range(0, 3) != 0);
        b_if.we    = 1'($urandom_range(0, 1));
        b_if.addr  = rand_addr();
        b_if.wdata = $urandom;
      end
    end
    a_if.valid = 0;
    b_if.valid = 0;
    repeat (3) step();

    // Reset lands while a read response is still in flight.
    req(1'b0, 1'b0, 32'd5, 32'h0);
    rstn = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    a_if.valid = 1; a_if.we = 0; a_if.addr = 32'd5;
    b_if.valid = 1; b_if.we = 0; b_if.addr = 32'd7;
    step();
    chk("post_reset_grant", {af, bf}, 2'b10);
    a_if.valid = 0;
    b_if.valid = 0;
    repeat (3) step();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end
endmodule
